// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner tag,
// latched memory command and the word-address helper.
package mem_port_arbiter_pkg;

  typedef logic [31:0] uint32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I_ACC,
    ARB_D_ACC
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam logic [3:0] MEM_BE_ALL = 4'b1111;

  typedef struct packed {
    uint32      addr;
    logic       we;
    uint32      wdata;
    logic [3:0] be;
    arb_owner_t owner;
  } mem_cmd_t;

  function automatic uint32 word_addr(input uint32 byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating fetch-starvation counter: counts lost arbitration cycles,
// clears on a fetch grant and flags when the limit is reached.
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v >= LIM) ? LIM : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported memory shared by instruction fetch
// and load/store. Data wins by default; the starvation counter forces fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int COUNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  arb_state_t state, state_nx;
  mem_cmd_t   cmd_p1;
  logic       free, done, i_done, d_done;
  logic       i_bad, d_bad, starve_hit;

  // Arbiter is free when idle or when the running access completes this cycle.
  assign free   = (state == ARB_IDLE) || mem_done;
  assign done   = (state != ARB_IDLE) && mem_done;
  assign i_done = done && (cmd_p1.owner == OWN_I);
  assign d_done = done && (cmd_p1.owner == OWN_D);
  assign i_bad  = (i_addr[1:0] != 2'b00);
  assign d_bad  = (d_be == 4'b0000);

  starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (COUNT_W)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (free && i_req && !i_gnt),
    .clr   (i_gnt),
    .hit   (starve_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (free) begin
      if (i_gnt && !i_bad)      state_nx = ARB_I_ACC;
      else if (d_gnt && !d_bad) state_nx = ARB_D_ACC;
      else                      state_nx = ARB_IDLE;
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (rst_n && free) begin
      if (i_req && (!d_req || starve_hit)) i_gnt = 1'b1;
      else if (d_req)                      d_gnt = 1'b1;
    end
    if (state != ARB_IDLE) begin
      mem_en    = 1'b1;
      mem_we    = cmd_p1.we;
      mem_addr  = cmd_p1.addr;
      mem_wdata = cmd_p1.wdata;
      mem_be    = cmd_p1.be;
    end
  end

  // Stage p1: command register feeding the memory port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_p1 <= '0;
    end else if (i_gnt && !i_bad) begin
      cmd_p1 <= '{addr: word_addr(i_addr), we: 1'b0, wdata: '0,
                  be: MEM_BE_ALL, owner: OWN_I};
    end else if (d_gnt && !d_bad) begin
      cmd_p1 <= '{addr: word_addr(d_addr), we: d_we, wdata: d_wdata,
                  be: d_be, owner: OWN_D};
    end
  end

  // Stage p2: registered responses; error grants answer without a memory access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= i_done || (i_gnt && i_bad);
      i_err    <= i_gnt && i_bad;
      if (i_done)              i_rdata <= mem_rdata;
      else if (i_gnt && i_bad) i_rdata <= '0;
      d_rvalid <= d_done || (d_gnt && d_bad);
      d_err    <= d_gnt && d_bad;
      if (d_done)              d_rdata <= cmd_p1.we ? '0 : mem_rdata;
      else if (d_gnt && d_bad) d_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  logic        use_fixed = 1'b0;
  logic [31:0] fixed_val = '0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rdata = use_fixed ? fixed_val : memword(mem_addr);

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_be = 4'hF; mem_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({i_rvalid, i_err, d_rvalid, d_err} !== 4'b0) begin bad++; $display("FAIL rst_rvalid_err got=%b exp=0000", {i_rvalid, i_err, d_rvalid, d_err}); end
    total++; if ({mem_en, mem_we, mem_be} !== 6'b0) begin bad++; $display("FAIL rst_mem got=%b exp=000000", {mem_en, mem_we, mem_be}); end
    total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0", i_rdata, d_rdata); end
    i_req = 1; d_req = 1; #1;
    total++; if ({i_gnt, d_gnt} !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", {i_gnt, d_gnt}); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_reset_mid_access();
    bit seen = 0;
    @(negedge clk);
    d_req = 1; d_addr = 32'h40; d_we = 0; d_be = 4'hF; mem_done = 0; #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", d_gnt); end
    @(negedge clk); d_req = 0; #1;
    total++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL rmid_access got=%b/%h exp=1/00000040", mem_en, mem_addr); end
    @(negedge clk); rst_n = 0; #1;
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rmid_wait got=%b exp=1", mem_en); end
    @(negedge clk); #1;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rmid_abandon got=%b exp=0", mem_en); end
    rst_n = 1; mem_done = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (d_rvalid || mem_en) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_rvalid got=%b exp=0", seen); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    use_fixed = 1; fixed_val = 32'hA5A5_0001;
    @(negedge clk);
    mem_done = 1; d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt k=%0d got=%b exp=1", k, d_gnt); end
      if (k >= 1) begin
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL b2b_mem k=%0d got=%b/%h exp=1/00000200", k, mem_en, mem_addr); end
      end
      if (k >= 2) begin
        total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL b2b_rsp k=%0d got=%b/%h exp=1/a5a50001", k, d_rvalid, d_rdata); end
      end
    end
    @(negedge clk); d_req = 0; #1;
    total++; if ({d_gnt, mem_en, d_rvalid} !== 3'b011) begin bad++; $display("FAIL b2b_drain1 got=%b exp=011", {d_gnt, mem_en, d_rvalid}); end
    @(negedge clk); #1;
    total++; if ({mem_en, d_rvalid} !== 2'b01) begin bad++; $display("FAIL b2b_drain2 got=%b exp=01", {mem_en, d_rvalid}); end
    @(negedge clk); #1;
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_drain3 got=%b exp=0", d_rvalid); end
    idle_inputs();
  endtask

  task automatic test_store();
    use_fixed = 1; fixed_val = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_done = 1; d_req = 1; d_we = 1; d_be = 4'b0100; d_wdata = 32'h00CC_0000; d_addr = 32'h302; #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL st_gnt got=%b exp=1", d_gnt); end
    @(negedge clk); d_req = 0; #1;
    total++; if ({mem_en, mem_we, mem_be} !== 6'b11_0100 || mem_wdata !== 32'h00CC_0000 || mem_addr !== 32'h300)
      begin bad++; $display("FAIL st_mem got=%b/%h/%h exp=110100/00cc0000/00000300", {mem_en, mem_we, mem_be}, mem_wdata, mem_addr); end
    @(negedge clk); #1;
    total++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h0) begin bad++; $display("FAIL st_rsp got=%b/%h exp=10/00000000", {d_rvalid, d_err}, d_rdata); end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    use_fixed = 1; fixed_val = 32'h1111_0104;
    @(negedge clk);
    i_req = 1; i_addr = 32'h104; mem_done = 0; #1;
    total++; if (i_gnt !== 1'b1) begin bad++; $display("FAIL ws_gnt got=%b exp=1", i_gnt); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); i_req = 0; mem_done = (k == 4); #1;
      total++; if ({mem_en, i_rvalid} !== 2'b10 || mem_addr !== 32'h104) begin bad++; $display("FAIL ws_hold k=%0d got=%b/%h exp=10/00000104", k, {mem_en, i_rvalid}, mem_addr); end
    end
    @(negedge clk); mem_done = 0; #1;
    total++; if ({i_rvalid, i_err, mem_en} !== 3'b100 || i_rdata !== 32'h1111_0104) begin bad++; $display("FAIL ws_rsp got=%b/%h exp=100/11110104", {i_rvalid, i_err, mem_en}, i_rdata); end
    @(negedge clk); #1;
    total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL ws_pulse got=%b exp=0", i_rvalid); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic exp_i;
    use_fixed = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    mem_done = 1; i_req = 1; i_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_i = ((k % (LIMIT + 1)) == LIMIT);
      total++; if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin bad++; $display("FAIL starve k=%0d got=%b exp=%b", k, {i_gnt, d_gnt}, {exp_i, ~exp_i}); end
    end
    @(negedge clk); idle_inputs(); mem_done = 1;
    repeat (3) @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_errors();
    @(negedge clk);
    i_req = 1; i_addr = 32'h0000_0102; mem_done = 0; #1;
    total++; if (i_gnt !== 1'b1) begin bad++; $display("FAIL err_i_gnt got=%b exp=1", i_gnt); end
    @(negedge clk); i_req = 0; #1;
    total++; if ({i_rvalid, i_err, mem_en} !== 3'b110 || i_rdata !== 32'h0) begin bad++; $display("FAIL err_i_rsp got=%b/%h exp=110/00000000", {i_rvalid, i_err, mem_en}, i_rdata); end
    @(negedge clk);
    d_req = 1; d_we = 1; d_be = 4'b0000; d_addr = 32'h80; d_wdata = 32'hFFFF; #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL err_d_gnt got=%b exp=1", d_gnt); end
    @(negedge clk); d_req = 0; #1;
    total++; if ({d_rvalid, d_err, mem_en, mem_we} !== 4'b1100 || d_rdata !== 32'h0) begin bad++; $display("FAIL err_d_rsp got=%b/%h exp=1100/00000000", {d_rvalid, d_err, mem_en, mem_we}, d_rdata); end
    @(negedge clk); #1;
    total++; if ({d_rvalid, d_err, i_rvalid, i_err} !== 4'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0000", {d_rvalid, d_err, i_rvalid, i_err}); end
    idle_inputs();
  endtask

  task automatic test_random();
    bit busy = 0, cur_i = 0, cur_we = 0;
    logic [31:0] cur_addr = 0, cur_wdata = 0;
    logic [3:0]  cur_be = 0;
    int starve = 0;
    bit er_i = 0, ee_i = 0, er_d = 0, ee_d = 0;
    logic [31:0] ed_i = 0, ed_d = 0;
    bit n_er_i, n_ee_i, n_er_d, n_ee_d, nb;
    logic [31:0] n_ed_i, n_ed_d;
    bit gi_last = 0, gd_last = 0, out_i = 0, out_d = 0;
    bit free, egi, egd;
    use_fixed = 0;
    @(negedge clk); idle_inputs(); rst_n = 0;
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (gi_last) i_req = 0;
      if (gd_last) d_req = 0;
      if (!i_req && !out_i && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom();
        if ($urandom_range(0, 7) != 0) i_addr[1:0] = 2'b00;
      end
      if (!d_req && !out_d && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom(); d_wdata = $urandom();
        d_be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      mem_done = 1'($urandom_range(0, 1));
      #1;
      free = !busy || mem_done;
      egi  = free && i_req && (!d_req || starve == LIMIT);
      egd  = free && d_req && !egi;
      total++; if ({i_gnt, d_gnt} !== {egi, egd}) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {i_gnt, d_gnt}, {egi, egd}); end
      total++; if (mem_en !== busy) begin bad++; $display("FAIL rnd_mem_en c=%0d got=%b exp=%b", c, mem_en, busy); end
      if (busy) begin
        total++; if (mem_addr !== cur_addr || mem_we !== cur_we || mem_be !== cur_be || (cur_we && mem_wdata !== cur_wdata))
          begin bad++; $display("FAIL rnd_cmd c=%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h", c, mem_addr, mem_we, mem_be, mem_wdata, cur_addr, cur_we, cur_be, cur_wdata); end
      end
      total++; if ({i_rvalid, d_rvalid} !== {er_i, er_d}) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {i_rvalid, d_rvalid}, {er_i, er_d}); end
      if (er_i) begin
        total++; if (i_err !== ee_i || i_rdata !== ed_i) begin bad++; $display("FAIL rnd_i_rsp c=%0d got=%b/%h exp=%b/%h", c, i_err, i_rdata, ee_i, ed_i); end
      end
      if (er_d) begin
        total++; if (d_err !== ee_d || d_rdata !== ed_d) begin bad++; $display("FAIL rnd_d_rsp c=%0d got=%b/%h exp=%b/%h", c, d_err, d_rdata, ee_d, ed_d); end
      end
      if (er_i) out_i = 0;
      if (er_d) out_d = 0;
      n_er_i = 0; n_ee_i = 0; n_ed_i = 0; n_er_d = 0; n_ee_d = 0; n_ed_d = 0;
      if (busy && mem_done) begin
        if (cur_i) begin n_er_i = 1; n_ed_i = memword(cur_addr); end
        else begin n_er_d = 1; n_ed_d = cur_we ? 32'h0 : memword(cur_addr); end
      end
      nb = free ? 1'b0 : busy;
      if (egi) starve = 0;
      else if (free && i_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      if (egi) begin
        out_i = 1;
        if (i_addr[1:0] != 2'b00) begin n_er_i = 1; n_ee_i = 1; n_ed_i = 0; end
        else begin nb = 1; cur_i = 1; cur_addr = {i_addr[31:2], 2'b00}; cur_we = 0; cur_be = 4'hF; end
      end
      if (egd) begin
        out_d = 1;
        if (d_be == 4'h0) begin n_er_d = 1; n_ee_d = 1; n_ed_d = 0; end
        else begin nb = 1; cur_i = 0; cur_addr = {d_addr[31:2], 2'b00}; cur_we = d_we; cur_be = d_be; cur_wdata = d_wdata; end
      end
      busy = nb; gi_last = egi; gd_last = egd;
      er_i = n_er_i; ee_i = n_ee_i; ed_i = n_ed_i;
      er_d = n_er_d; ee_d = n_ee_d; ed_d = n_ed_d;
    end
    @(negedge clk); idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_reset_mid_access();
    test_back_to_back();
    test_store();
    test_wait_states();
    test_starvation();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-ported unified memory shared by the instruction-fetch port and the load/store port of the core.
- Accepts one request per cycle from either requester and drives the memory command.
- Handles variable memory wait states and returns registered responses to the owning requester.
- Load/store requests win by default; a starvation counter guarantees fetch progress.
- Sits between the fetch/LSU stages (the LSU computes byte enables and lane alignment upstream) and the memory macro.

## Interface
Parameters:
- STARVE_LIMIT, 4 — consecutive fetch-losing cycles after which fetch gets priority (1..15)
- COUNT_W, 4 — starvation counter width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid (1-cycle pulse)
- i_rdata  out  32  fetch data (uint32)
- i_err  out  1  fetch misaligned, valid with i_rvalid
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, already lane-aligned
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (loads and stores)
- d_rdata  out  32  raw memory word
- d_err  out  1  d_be == 0, valid with d_rvalid
- mem_en  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  32  word address (byte address with [1:0] = 0)
- mem_wdata  out  32  write data
- mem_be  out  4  write byte mask
- mem_rdata  in  32  read data, valid when mem_done is high
- mem_done  in  1  access completes this cycle

## Operation
- FSM states: IDLE, I_ACC, D_ACC.
- **Arbitration** happens when the arbiter is free, i.e. in IDLE or in the completion cycle of I_ACC/D_ACC (mem_done = 1).
  - Both requests pending: data wins unless starve_cnt == STARVE_LIMIT, then fetch wins.
  - Exactly one gnt pulses, and only in the cycle it is issued.
- **Grant**: the command (addr, we, wdata, be, owner) is latched into registers and the FSM enters I_ACC or D_ACC.
  - In I_ACC/D_ACC: mem_en = 1 and mem_* is driven from the command registers, held stable until mem_done.
  - mem_we = 0 and mem_be = 4'b1111 for fetch.
- **Completion** (mem_done in I_ACC/D_ACC):
  - The owner's rvalid is pulsed on the next cycle.
  - rdata is registered from mem_rdata; for stores rdata = 0.
  - The FSM goes to the newly granted state, otherwise IDLE.
- **Errors**:
  - i_addr[1:0] ≠ 0 or d_be == 0: the request is still granted but the memory is not accessed (state goes IDLE, or stays free).
  - rvalid and err pulse 1 cycle after the grant; rdata = 0.
- **Starvation counter starve_cnt** (COUNT_W bits, unsigned):
  - +1 each cycle i_req = 1 and i_gnt = 0 while the arbiter is free.
  - Saturates at STARVE_LIMIT.
  - Cleared on i_gnt.
- Responses are never back-pressured; each port has at most one outstanding request.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - State IDLE, starve_cnt = 0, command registers = 0.
  - All gnt/rvalid/err/mem_en/mem_we = 0; rdata = 0; mem_be = 0.
  - An in-flight access is abandoned and no rvalid follows.
- Grant is combinational from req in a free cycle.
- Memory access starts the cycle after the grant.
- Zero-wait memory (mem_done in the first access cycle): grant at N, mem_en at N+1, rvalid at N+2. Sustained throughput is 1 access/cycle.
- Each wait state adds one cycle.
- mem_done while in IDLE is ignored.
- If req is deasserted before being granted, no action is taken.
- i_rvalid and d_rvalid never assert in the same cycle, except an error response coinciding with a memory completion. Both are permitted, since they target different ports.

## Structure
- Add to package Common:
  - arb_state_t enum {ARB_IDLE, ARB_I_ACC, ARB_D_ACC}
  - arb_owner_t enum {OWN_I, OWN_D}
  - Constant MEM_BE_ALL = 4'b1111
- Uses the existing uint32 type.
- One natural sub-module: starve_counter (saturating counter with clear and compare-to-limit). Everything else stays inline.

## Test plan
- Reset mid-access: grant d at cycle 2, hold mem_done = 0, rst_n = 0 at cycle 4 → mem_en = 0 at 5, no d_rvalid ever, state IDLE.
- Zero-wait back-to-back: d_req held, mem_done = 1, mem_rdata = 32'hA5A5_0001 → d_gnt every cycle, d_rvalid at N+2 with d_rdata = 32'hA5A5_0001.
- Wait states: fetch of 32'h0000_0104, mem_done low 3 cycles → mem_addr = 32'h104 stable 4 cycles, i_rvalid 1 cycle after mem_done.
- Starvation, STARVE_LIMIT = 4: i_req and d_req held continuously → 4 d grants, then i_gnt, starve_cnt back to 0.
- Errors: i_addr = 32'h0000_0102 → i_rvalid + i_err at N+1, mem_en stays 0; d_be = 0 → d_err at N+1, no memory write.
- Store: d_we = 1, d_be = 4'b0100, d_wdata = 32'h00CC_0000 → mem_we = 1, mem_be = 4'b0100, d_rvalid with d_rdata = 0.
